// File: rtl/data_mem_controller_pkg.sv
// Shared types for the data-memory path: pipeline request, bus bundle and controller states.
package data_mem_controller_pkg;

    typedef logic [31:0] word;

    typedef enum logic {
        MEM_READ_EN  = 1'b0,
        MEM_WRITE_EN = 1'b1
    } memory_op_t;

    typedef struct packed {
        logic       mem_enable;
        memory_op_t mem_en;
        word        address;
        word        data_in;
    } data_memory_interface_t;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_BUSY,
        DMEM_DONE
    } dmem_state_t;

    localparam int DMEM_TIMEOUT_DEFAULT = 16;

    typedef struct packed {
        logic req;
        logic we;
        word  addr;
        word  wdata;
    } data_bus_interface_t;

    function automatic logic is_misaligned(input word addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_controller_timeout_counter.sv
// Bus watchdog: counts enabled cycles from a clear and flags when LIMIT-1 is reached.
module dmem_timeout_counter
    import data_mem_controller_pkg::*;
#(
    parameter int LIMIT = DMEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = (count_q == CW'(LIMIT - 1));

    // Saturates at the terminal value so it is never compared past the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/data_mem_controller.sv
// Turns single-cycle memory-stage requests into req/ack bus transactions,
// stalling the pipeline until completion, with alignment and timeout errors.
module data_mem_controller
    import data_mem_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
    parameter bit ALIGN_CHECK    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  data_memory_interface_t mem_sig,
    output word                    mem_data_out,
    output logic                   mem_stall,
    output logic                   mem_error,
    output logic                   bus_req,
    output logic                   bus_we,
    output word                    bus_addr,
    output word                    bus_wdata,
    input  word                    bus_rdata,
    input  logic                   bus_ack
);

    dmem_state_t         state_q;
    data_bus_interface_t bus_q;
    word                 rdata_q;
    logic                err_q;
    logic                misaligned;
    logic                expired;

    assign misaligned = ALIGN_CHECK && is_misaligned(mem_sig.address);

    dmem_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != DMEM_BUSY),
        .enable_i (state_q == DMEM_BUSY),
        .expired_o(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            bus_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                DMEM_IDLE: begin
                    if (mem_sig.mem_enable) begin
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= DMEM_DONE;
                        end else begin
                            bus_q.req   <= 1'b1;
                            bus_q.we    <= (mem_sig.mem_en == MEM_WRITE_EN);
                            bus_q.addr  <= mem_sig.address;
                            bus_q.wdata <= mem_sig.data_in;
                            state_q     <= DMEM_BUSY;
                        end
                    end
                end
                DMEM_BUSY: begin
                    // An ack arriving in the timeout cycle still completes cleanly.
                    if (bus_ack) begin
                        rdata_q   <= bus_q.we ? '0 : bus_rdata;
                        bus_q.req <= 1'b0;
                        state_q   <= DMEM_DONE;
                    end else if (expired) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        bus_q.req <= 1'b0;
                        state_q   <= DMEM_DONE;
                    end
                end
                DMEM_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= DMEM_IDLE;
                end
                default: begin
                    state_q <= DMEM_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            case (state_q)
                DMEM_IDLE: mem_stall = mem_sig.mem_enable;
                DMEM_BUSY: mem_stall = 1'b1;
                default:   mem_stall = 1'b0;
            endcase
        end
    end

    assign mem_error    = !rst && (state_q == DMEM_DONE) && err_q;
    assign mem_data_out = rdata_q;
    assign bus_req      = bus_q.req;
    assign bus_we       = bus_q.we;
    assign bus_addr     = bus_q.addr;
    assign bus_wdata    = bus_q.wdata;

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: directed cases followed by randomized accesses
// against a latency/outcome model derived from the access rules.
module tb_data_mem_controller;
    import data_mem_controller_pkg::*;

    localparam int T = 4;

    logic                   clk;
    logic                   rst;
    data_memory_interface_t mem_sig;
    word                    mem_data_out;
    logic                   mem_stall;
    logic                   mem_error;
    logic                   bus_req;
    logic                   bus_we;
    word                    bus_addr;
    word                    bus_wdata;
    word                    bus_rdata;
    logic                   bus_ack;

    int  checks = 0;
    int  errors = 0;
    word last_data = '0;

    data_mem_controller #(
        .TIMEOUT_CYCLES(T),
        .ALIGN_CHECK   (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_sig     (mem_sig),
        .mem_data_out(mem_data_out),
        .mem_stall   (mem_stall),
        .mem_error   (mem_error),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts just after a rising edge with the controller idle; returns just after
    // the edge that closes the DONE cycle. The bench plays the bus: ack comes after
    // 'waits' wait cycles of bus_req, or never if that exceeds the watchdog.
    task automatic run_access(input string name, input word addr, input logic we,
                              input word wd, input int waits, input word rd);
        int   stall_n = 0;
        int   breq_n  = 0;
        int   err_n   = 0;
        int   hold_bad = 0;
        int   bus_bad  = 0;
        bit   done    = 0;
        logic mis;
        int   exp_stall;
        int   exp_breq;
        logic exp_err;
        word  exp_data;

        mis = (addr % 4) != 0;
        if (mis) begin
            exp_stall = 1; exp_breq = 0; exp_err = 1'b1; exp_data = '0;
        end else if (waits < T) begin
            exp_stall = waits + 2; exp_breq = waits + 1; exp_err = 1'b0;
            exp_data = we ? 32'h0 : rd;
        end else begin
            exp_stall = T + 1; exp_breq = T; exp_err = 1'b1; exp_data = '0;
        end

        mem_sig.mem_enable = 1'b1;
        mem_sig.mem_en     = we ? MEM_WRITE_EN : MEM_READ_EN;
        mem_sig.address    = addr;
        mem_sig.data_in    = wd;

        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (mem_error) err_n++;
            if (bus_req) begin
                if (bus_addr !== addr || bus_we !== we || bus_wdata !== wd) bus_bad++;
                bus_ack   = (breq_n == waits);
                bus_rdata = bus_ack ? rd : $urandom;
                breq_n++;
            end else begin
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
            if (mem_stall) begin
                stall_n++;
                if (mem_data_out !== last_data) hold_bad++;
            end else begin
                done = 1;
                check({name, "_data"}, mem_data_out, exp_data);
                check({name, "_err_done"}, 32'(mem_error), 32'(exp_err));
            end
        end
        check({name, "_completed"}, 32'(done), 32'd1);
        check({name, "_stall_cycles"}, stall_n, exp_stall);
        check({name, "_req_cycles"}, breq_n, exp_breq);
        check({name, "_err_pulses"}, err_n, 32'(exp_err));
        check({name, "_bus_stable"}, bus_bad, 0);
        check({name, "_data_hold"}, hold_bad, 0);

        @(posedge clk);
        #1;
        mem_sig.mem_enable = 1'b0;
        bus_ack            = 1'b0;
        last_data          = exp_data;
    endtask

    initial begin
        rst       = 1'b1;
        mem_sig   = '{mem_enable: 1'b1, mem_en: MEM_READ_EN, address: 32'h40, data_in: 32'h0};
        bus_ack   = 1'b0;
        bus_rdata = '0;
        #3;
        check("rst_stall", 32'(mem_stall), 0);
        check("rst_error", 32'(mem_error), 0);
        check("rst_req", 32'(bus_req), 0);
        check("rst_addr", bus_addr, 0);
        check("rst_data", mem_data_out, 0);
        mem_sig.mem_enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("idle_stall", 32'(mem_stall), 0);

        run_access("rd_first", 32'h100, 1'b0, 32'h0, 0, 32'hDEADBEEF);
        run_access("wr_wait3", 32'h204, 1'b1, 32'h12345678, 3, 32'hCAFEF00D);
        run_access("misalign", 32'h103, 1'b0, 32'h0, 0, 32'h11111111);
        run_access("timeout", 32'h080, 1'b0, 32'h0, 50, 32'h22222222);
        run_access("after_to", 32'h084, 1'b0, 32'h0, 0, 32'hA5A5A5A5);

        // Reset lands in the middle of a bus transaction.
        mem_sig = '{mem_enable: 1'b1, mem_en: MEM_READ_EN, address: 32'h300, data_in: 32'h0};
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_req", 32'(bus_req), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus_req), 0);
        check("mid_rst_stall", 32'(mem_stall), 0);
        check("mid_rst_data", mem_data_out, 0);
        mem_sig.mem_enable = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h77777777;
        @(negedge clk);
        check("late_ack_req", 32'(bus_req), 0);
        check("late_ack_stall", 32'(mem_stall), 0);
        @(negedge clk);
        check("late_ack_req2", 32'(bus_req), 0);
        check("late_ack_err", 32'(mem_error), 0);
        check("late_ack_data", mem_data_out, 0);
        bus_ack = 1'b0;
        @(posedge clk);
        #1;
        last_data = '0;

        run_access("b2b_a", 32'h10, 1'b0, 32'h0, 0, 32'h0000AAAA);
        run_access("b2b_b", 32'h14, 1'b0, 32'h0, 0, 32'h0000BBBB);

        for (int i = 0; i < 40; i++) begin
            word a;
            a = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            run_access("rand", a, 1'($urandom_range(0, 1)), $urandom,
                       $urandom_range(0, 6), $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                bus_ack = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                bus_ack = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Sits directly downstream of the memory stage. Consumes its data-memory request (data_memory_interface_t) and returns mem_data_out to it.
- Converts the single-cycle request into a req/ack transaction on a variable-latency data bus.
- Stalls the pipeline until the access completes.
- Provides word-alignment checking and a bus-timeout watchdog that reports an error instead of hanging the core.

Parameters:
- TIMEOUT_CYCLES, 16: BUSY cycles without bus_ack before the access is aborted with an error; must be >= 1.
- ALIGN_CHECK, 1: 1 = reject accesses with address[1:0] != 0; 0 = pass the address through unchecked.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_sig  in  data_memory_interface_t  request from memory stage (mem_enable, mem_en, address, data_in).
- mem_data_out  out  word  read data returned to memory stage.
- mem_stall  out  1  pipeline hold request; memory stage inputs held stable while 1.
- mem_error  out  1  one-cycle pulse in the completion cycle of a misaligned or timed-out access.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req.
- bus_addr  out  word  byte address, word-aligned.
- bus_wdata  out  word  write data.
- bus_rdata  in  word  read data; sampled when bus_ack=1.
- bus_ack  in  1  single-cycle completion strobe from bus.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata_q=0, timeout counter=0.
  - mem_stall and mem_error are forced 0 while rst=1.
- IDLE:
  - mem_enable=0: mem_stall=0, no transition.
  - mem_enable=1, address aligned (or ALIGN_CHECK=0):
    - mem_stall=1 combinationally.
    - Latch address, data_in, and we=(mem_en==MEM_WRITE_EN) into the bus registers; set bus_req=1; counter=0; go to BUSY.
  - mem_enable=1, misaligned with ALIGN_CHECK=1: mem_stall=1; no bus activity; set err_q=1, rdata_q=0; go to DONE.
- BUSY:
  - mem_stall=1; bus_req held 1; bus_addr, bus_wdata and bus_we held constant.
  - bus_ack=1: capture bus_rdata into rdata_q for reads (writes capture 0); bus_req=0; go to DONE.
  - bus_ack=0 and counter==TIMEOUT_CYCLES-1: bus_req=0; rdata_q=0; err_q=1; go to DONE.
  - Otherwise counter increments by 1. The counter saturates and is never compared past the limit.
- DONE:
  - mem_stall=0; mem_data_out=rdata_q; mem_error=err_q.
  - Unconditionally go to IDLE, clearing err_q. The memory stage and pipeline advance at the end of this cycle.
- mem_data_out equals rdata_q in all states; it holds its last value outside DONE.
- Latency: an access acknowledged in its first BUSY cycle gives mem_stall high for 2 cycles (IDLE-detect, BUSY) and data valid in the DONE cycle. Each extra wait cycle adds 1.
- Back-to-back accesses: the next request is evaluated in IDLE the cycle after DONE. No request is accepted in DONE.
- bus_ack while in IDLE or DONE is ignored.
- bus_ack in the same cycle as a timeout: ack wins, with no error.
- Reset during BUSY: bus_req drops asynchronously and the in-flight access is abandoned. The bus must tolerate a withdrawn request.
- Width rules: all data and addresses are 32-bit word. The counter is $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package (params.sv), alongside word, memory_op_t and data_memory_interface_t:
  - dmem_state_t enum {DMEM_IDLE, DMEM_BUSY, DMEM_DONE}.
  - DMEM_TIMEOUT_DEFAULT constant.
  - data_bus_interface_t struct {req, we, addr, wdata}.
- One sub-module: dmem_timeout_counter (clear, enable, expired), reusable by a future instruction-fetch bus controller.

Test Plan:
- Read, ack in first BUSY cycle, bus_rdata=0xDEADBEEF, address 0x100 -> bus_addr=0x100, bus_we=0; mem_stall high exactly 2 cycles; mem_data_out=0xDEADBEEF in DONE; mem_error=0.
- Write of 0x12345678 to 0x204, ack after 3 wait cycles -> bus_we=1; bus_wdata=0x12345678 stable all 4 BUSY cycles; mem_stall high 5 cycles; mem_data_out=0.
- Read from 0x103 with ALIGN_CHECK=1 -> bus_req never asserts; mem_stall high 1 cycle; mem_error pulses 1 cycle; mem_data_out=0.
- Read, bus_ack never asserted, TIMEOUT_CYCLES=4 -> bus_req high exactly 4 cycles, then DONE with mem_error=1 and mem_data_out=0. Then a second read acked normally completes without error.
- Assert rst mid-BUSY -> bus_req=0 and mem_stall=0 in the same cycle without waiting for a clock edge. After release, a late bus_ack is ignored and state is IDLE.
- Two reads back-to-back (0x10 then 0x14, each acked immediately) -> DONE, IDLE, BUSY sequence; bus_addr 0x10 then 0x14; correct data per access; no cycle overlap.
